mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Parametrised N-master request arbiter for the line-based memory path between the cache, UART loader and other bus masters and the DRAM AXI bridge. It replaces the fixed two-master front end with NMST masters and round-robin fairness across all write and read request slots. It keeps one transaction outstanding downstream and routes completion and read-data strobes back to the owning master. It also flags protocol overruns.

## Interface
- NMST, 3, number of masters (1..8)
- AWIDTH, 32, request address width
- LWIDTH, 128, line data width; mask width is LWIDTH/8
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- m_wstart_rq  in  NMST  per-master 1-cycle write request pulse
- m_win_addr  in  NMST*AWIDTH  write address, master i at [i*AWIDTH +: AWIDTH]
- m_in_wdata  in  NMST*LWIDTH  write line data
- m_in_mask  in  NMST*LWIDTH/8  write byte mask
- m_finish_wresp  out  NMST  write-complete pulse to the owning master
- m_rstart_rq  in  NMST  per-master 1-cycle read request pulse
- m_rin_addr  in  NMST*AWIDTH  read address
- m_rdat_data  out  LWIDTH  read data, broadcast to all masters
- m_rdat_valid  out  NMST  read-data strobe, owner only
- m_finish_mrd  out  NMST  read-complete pulse to the owning master
- s_wstart_rq  out  1  downstream write request pulse
- s_win_addr / s_in_wdata / s_in_mask  out  AWIDTH / LWIDTH / LWIDTH/8  muxed write payload
- s_finish_wresp  in  1  downstream write complete
- s_rstart_rq  out  1  downstream read request pulse
- s_rin_addr  out  AWIDTH  muxed read address
- s_rdat_data  in  LWIDTH  downstream read data
- s_rdat_valid  in  1  downstream read-data strobe
- s_finish_mrd  in  1  downstream read complete
- busy  out  1  transaction outstanding
- grant_slot  out  4  last granted slot index
- err_ovr  out  NMST  sticky: master pulsed a request while its same-type request was still pending

## Operation
- Slots: there are 2*NMST slots. Slot 2i is the write of master i. Slot 2i+1 is the read of master i.
- Pending bit per slot:
  - Set on the request pulse.
  - Cleared on the cycle its finish is accepted.
  - A pulse while the bit is already set is ignored and sets err_ovr[i]. err_ovr clears only on reset.
- Payload handling: no payload is captured. The master holds addr/data/mask stable from its pulse until its finish. Downstream payload outputs are muxed from the granted slot's master, and are zero in IDLE.
- FSM states: IDLE, ISSUE, WAIT_W, WAIT_R.
  - IDLE: if any pending bit is set, pick the first set slot searching upward (with wrap) from grant_slot+1. Register the selection as grant_slot and go to ISSUE.
  - ISSUE: assert s_wstart_rq (even slot) or s_rstart_rq (odd slot) for exactly one cycle. Then go to WAIT_W or WAIT_R.
  - WAIT_W: on s_finish_wresp, clear the pending bit, register m_finish_wresp[owner] for 1 cycle, and go to IDLE.
  - WAIT_R: m_rdat_valid[owner] = s_rdat_valid, combinational. m_rdat_data = s_rdat_data always. On s_finish_mrd, clear the pending bit, register m_finish_mrd[owner] for 1 cycle, and go to IDLE.
- busy is 1 in ISSUE, WAIT_W and WAIT_R.
- Ignored inputs:
  - Finish strobes in IDLE or ISSUE.
  - A finish of the wrong type.
  - s_rdat_valid outside WAIT_R. All m_rdat_valid stay 0.
- Simultaneous pulse and finish on the same slot: clear wins and the pulse is counted as overrun. Masters must not do this.
- Reset (async, any state):
  - FSM goes to IDLE; all pending and err_ovr bits clear.
  - grant_slot resets to 2*NMST-1, so slot 0 has first priority.
  - All outputs reset to 0 and the downstream payload outputs read 0.
  - An in-flight downstream transaction is abandoned. Its later finish arrives in IDLE and is ignored.

## Timing
- Request pulse at cycle T: pending set at T+1, selection registered at end of T+1, s_*start_rq high during T+2.
- Downstream finish at cycle F: m_finish_* high during F+1, FSM in IDLE at F+1.
- Next grant pulse: earliest F+3, giving a 3-cycle turnaround.
- m_rdat_valid: zero-latency pass-through of s_rdat_valid.
- Round-robin fairness: with all 2*NMST slots continuously pending, every slot is granted once per 2*NMST grants.

## Test plan
- Single write: master 1 pulses m_wstart_rq, addr 0x0000_1000, mask 0xFFFF.
  - s_wstart_rq high 2 cycles later with s_win_addr 0x1000.
  - s_finish_wresp returned → m_finish_wresp = 3'b010 one cycle later.
- Single read: master 2 pulses m_rstart_rq, addr 0x2000; downstream gives 4 s_rdat_valid beats then s_finish_mrd.
  - m_rdat_valid = 3'b100 on exactly those 4 cycles; m_finish_mrd = 3'b100 once.
- Contention: all 3 masters pulse write and read in the same cycle after reset.
  - Grant order is slots 0,1,2,3,4,5.
  - busy drops only after the 6th finish.
- Fairness: master 0 re-requests its write immediately after each finish while master 2's read is pending.
  - Master 2's read is granted before master 0's second write.
- Overrun: master 0 pulses a write twice before its finish.
  - err_ovr = 3'b001 (sticky).
  - Only one s_wstart_rq is issued.
- Reset in WAIT_R: assert rst_n=0 mid-read.
  - All outputs go to 0 immediately.
  - After release, a stray s_finish_mrd produces no m_finish_mrd.
  - A new request is served normally starting from slot 0 priority.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Bundles the N-master request side and the single downstream port of the line-based
// memory arbiter; slave is the arbiter's view, master is the surrounding system's view.
interface mem_req_arbiter_if #(
   parameter int NMST   = 3,
   parameter int AWIDTH = 32,
   parameter int LWIDTH = 128
);
   localparam int MWIDTH = LWIDTH / 8;

   logic [NMST-1:0]        m_wstart_rq;
   logic [NMST*AWIDTH-1:0] m_win_addr;
   logic [NMST*LWIDTH-1:0] m_in_wdata;
   logic [NMST*MWIDTH-1:0] m_in_mask;
   logic [NMST-1:0]        m_finish_wresp;
   logic [NMST-1:0]        m_rstart_rq;
   logic [NMST*AWIDTH-1:0] m_rin_addr;
   logic [LWIDTH-1:0]      m_rdat_data;
   logic [NMST-1:0]        m_rdat_valid;
   logic [NMST-1:0]        m_finish_mrd;

   logic                   s_wstart_rq;
   logic [AWIDTH-1:0]      s_win_addr;
   logic [LWIDTH-1:0]      s_in_wdata;
   logic [MWIDTH-1:0]      s_in_mask;
   logic                   s_finish_wresp;
   logic                   s_rstart_rq;
   logic [AWIDTH-1:0]      s_rin_addr;
   logic [LWIDTH-1:0]      s_rdat_data;
   logic                   s_rdat_valid;
   logic                   s_finish_mrd;

   logic                   busy;
   logic [3:0]             grant_slot;
   logic [NMST-1:0]        err_ovr;

   modport slave (
      input  m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
      input  s_finish_wresp, s_rdat_data, s_rdat_valid, s_finish_mrd,
      output m_finish_wresp, m_rdat_data, m_rdat_valid, m_finish_mrd,
      output s_wstart_rq, s_win_addr, s_in_wdata, s_in_mask, s_rstart_rq, s_rin_addr,
      output busy, grant_slot, err_ovr
   );

   modport master (
      output m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
      output s_finish_wresp, s_rdat_data, s_rdat_valid, s_finish_mrd,
      input  m_finish_wresp, m_rdat_data, m_rdat_valid, m_finish_mrd,
      input  s_wstart_rq, s_win_addr, s_in_wdata, s_in_mask, s_rstart_rq, s_rin_addr,
      input  busy, grant_slot, err_ovr
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter over 2*NMST write/read request slots with one transaction
// outstanding downstream; completions and read strobes are routed back to the owner.
module mem_req_arbiter #(
   parameter int NMST   = 3,
   parameter int AWIDTH = 32,
   parameter int LWIDTH = 128
) (
   input logic               clk,
   input logic               rst_n,
   mem_req_arbiter_if.slave  bus
);
   localparam int MWIDTH = LWIDTH / 8;
   localparam int NSLOT  = 2 * NMST;
   localparam int OW     = (NMST > 1) ? $clog2(NMST) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_W, WAIT_R} state_t;

   state_t            state_q, state_d;
   logic [3:0]        grant_q, grant_d;
   logic [NSLOT-1:0]  pend_q, pend_d, pulse, clr;
   logic [NMST-1:0]   err_q, err_d, ovr;
   logic [NMST-1:0]   fin_w_q, fin_w_d, fin_r_q, fin_r_d;
   logic [NMST-1:0]   own_oh;
   logic [OW-1:0]     owner;
   logic [15:0]       pend_pad, gnt_oh;
   logic [3:0]        sel;
   logic [4:0]        cand;
   logic              holdoff, wstart, rstart;

   logic [AWIDTH-1:0] waddr [NMST];
   logic [AWIDTH-1:0] raddr [NMST];
   logic [LWIDTH-1:0] wdata [NMST];
   logic [MWIDTH-1:0] wmask [NMST];

   for (genvar gi = 0; gi < NMST; gi++) begin : g_mst
      assign pulse[2*gi]   = bus.m_wstart_rq[gi];
      assign pulse[2*gi+1] = bus.m_rstart_rq[gi];
      assign ovr[gi]       = (pend_q[2*gi] & pulse[2*gi]) | (pend_q[2*gi+1] & pulse[2*gi+1]);
      assign waddr[gi]     = bus.m_win_addr[gi*AWIDTH +: AWIDTH];
      assign raddr[gi]     = bus.m_rin_addr[gi*AWIDTH +: AWIDTH];
      assign wdata[gi]     = bus.m_in_wdata[gi*LWIDTH +: LWIDTH];
      assign wmask[gi]     = bus.m_in_mask[gi*MWIDTH +: MWIDTH];
   end

   assign owner    = OW'(grant_q >> 1);
   assign own_oh   = NMST'(1) << (grant_q >> 1);
   assign gnt_oh   = 16'(1) << grant_q;
   assign pend_pad = 16'(pend_q);
   // One settling cycle after a completion so the finished master can re-request
   // before the next arbitration round.
   assign holdoff  = (|fin_w_q) | (|fin_r_q);

   // Round-robin search from grant_q+1 with wrap; the nearest pending slot wins.
   always_comb begin
      sel  = grant_q;
      cand = '0;
      for (int k = NSLOT; k >= 1; k--) begin
         cand = {1'b0, grant_q} + 5'(k);
         if (cand >= 5'(NSLOT)) cand = cand - 5'(NSLOT);
         if (pend_pad[cand[3:0]]) sel = cand[3:0];
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      clr     = '0;
      fin_w_d = '0;
      fin_r_d = '0;
      wstart  = 1'b0;
      rstart  = 1'b0;
      case (state_q)
         IDLE: begin
            if ((|pend_q) && !holdoff) begin
               grant_d = sel;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (grant_q[0]) begin
               rstart  = 1'b1;
               state_d = WAIT_R;
            end else begin
               wstart  = 1'b1;
               state_d = WAIT_W;
            end
         end
         WAIT_W: begin
            if (bus.s_finish_wresp) begin
               clr     = gnt_oh[NSLOT-1:0];
               fin_w_d = own_oh;
               state_d = IDLE;
            end
         end
         WAIT_R: begin
            if (bus.s_finish_mrd) begin
               clr     = gnt_oh[NSLOT-1:0];
               fin_r_d = own_oh;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pend_d = (pend_q | pulse) & ~clr;
   assign err_d  = err_q | ovr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 4'(NSLOT - 1);
         pend_q  <= '0;
         err_q   <= '0;
         fin_w_q <= '0;
         fin_r_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         fin_w_q <= fin_w_d;
         fin_r_q <= fin_r_d;
      end
   end

   assign bus.s_wstart_rq    = wstart;
   assign bus.s_rstart_rq    = rstart;
   assign bus.s_win_addr     = (state_q != IDLE) ? waddr[owner] : '0;
   assign bus.s_rin_addr     = (state_q != IDLE) ? raddr[owner] : '0;
   assign bus.s_in_wdata     = (state_q != IDLE) ? wdata[owner] : '0;
   assign bus.s_in_mask      = (state_q != IDLE) ? wmask[owner] : '0;
   assign bus.m_finish_wresp = fin_w_q;
   assign bus.m_finish_mrd   = fin_r_q;
   assign bus.m_rdat_data    = bus.s_rdat_data;
   assign bus.m_rdat_valid   = (state_q == WAIT_R && bus.s_rdat_valid) ? own_oh : '0;
   assign bus.busy           = (state_q != IDLE);
   assign bus.grant_slot     = grant_q;
   assign bus.err_ovr        = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: single write/read, contention, fairness,
// overrun and mid-read reset, checked against hand-computed expectations.
module tb_mem_req_arbiter;
   localparam int NMST   = 3;
   localparam int AWIDTH = 32;
   localparam int LWIDTH = 128;
   localparam int MWIDTH = LWIDTH / 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [AWIDTH-1:0] slot_addr [6];

   mem_req_arbiter_if #(.NMST(NMST), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) bus ();

   mem_req_arbiter #(.NMST(NMST), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.s_wstart_rq || bus.s_rstart_rq) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("start_timeout", 64'd0, 64'd1);
   endtask

   // Wait for the next grant, check it, complete it and optionally re-pulse master 0 write.
   task automatic serve(input string tag, input int exp_slot, input bit repulse);
      bit ok;
      wait_start(ok);
      if (ok) begin
         check({tag, "_grant"}, 64'(bus.grant_slot), 64'(exp_slot));
         check({tag, "_rd"}, 64'(bus.s_rstart_rq), 64'(exp_slot % 2));
         if (exp_slot % 2 == 1) check({tag, "_raddr"}, 64'(bus.s_rin_addr), 64'(slot_addr[exp_slot]));
         else                   check({tag, "_waddr"}, 64'(bus.s_win_addr), 64'(slot_addr[exp_slot]));
         tick();
         check({tag, "_busy"}, 64'(bus.busy), 64'd1);
         if (exp_slot % 2 == 1) bus.s_finish_mrd = 1'b1;
         else                   bus.s_finish_wresp = 1'b1;
         tick();
         bus.s_finish_mrd   = 1'b0;
         bus.s_finish_wresp = 1'b0;
         if (exp_slot % 2 == 1) check({tag, "_fin"}, 64'(bus.m_finish_mrd), 64'(1 << (exp_slot / 2)));
         else                   check({tag, "_fin"}, 64'(bus.m_finish_wresp), 64'(1 << (exp_slot / 2)));
         if (repulse) begin
            bus.m_wstart_rq[0] = 1'b1;
            tick();
            bus.m_wstart_rq = '0;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      bit ok;
      int extra;
      n_checks = 0;
      n_fail   = 0;
      slot_addr[0] = 32'h0000_0100; slot_addr[1] = 32'h0000_0300;
      slot_addr[2] = 32'h0000_1000; slot_addr[3] = 32'h0000_0700;
      slot_addr[4] = 32'h0000_0900; slot_addr[5] = 32'h0000_2000;
      rst_n = 1'b0;
      bus.m_wstart_rq = '0; bus.m_rstart_rq = '0;
      bus.s_finish_wresp = 1'b0; bus.s_finish_mrd = 1'b0;
      bus.s_rdat_valid = 1'b0; bus.s_rdat_data = '0;
      for (int i = 0; i < NMST; i++) begin
         bus.m_win_addr[i*AWIDTH +: AWIDTH] = slot_addr[2*i];
         bus.m_rin_addr[i*AWIDTH +: AWIDTH] = slot_addr[2*i+1];
         bus.m_in_wdata[i*LWIDTH +: LWIDTH] = {4{32'hA000_0000 + 32'(i)}};
         bus.m_in_mask[i*MWIDTH +: MWIDTH]  = 16'hFFFF;
      end
      tick();
      tick();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_grant", 64'(bus.grant_slot), 64'd5);
      check("rst_err", 64'(bus.err_ovr), 64'd0);
      check("rst_waddr", 64'(bus.s_win_addr), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single write from master 1
      bus.m_wstart_rq[1] = 1'b1;
      tick();
      bus.m_wstart_rq = '0;
      check("w_start_early", 64'(bus.s_wstart_rq), 64'd0);
      tick();
      check("w_start", 64'(bus.s_wstart_rq), 64'd1);
      check("w_addr", 64'(bus.s_win_addr), 64'h1000);
      check("w_mask", 64'(bus.s_in_mask), 64'hFFFF);
      check("w_data", bus.s_in_wdata[63:0], 64'hA000_0001_A000_0001);
      tick();
      check("w_start_once", 64'(bus.s_wstart_rq), 64'd0);
      bus.s_finish_wresp = 1'b1;
      tick();
      bus.s_finish_wresp = 1'b0;
      check("w_fin", 64'(bus.m_finish_wresp), 64'b010);
      check("w_busy_low", 64'(bus.busy), 64'd0);
      tick();
      check("w_fin_pulse", 64'(bus.m_finish_wresp), 64'd0);

      // Single read from master 2 with 4 beats
      bus.m_rstart_rq[2] = 1'b1;
      tick();
      bus.m_rstart_rq = '0;
      tick();
      check("r_start", 64'(bus.s_rstart_rq), 64'd1);
      check("r_addr", 64'(bus.s_rin_addr), 64'h2000);
      check("r_grant", 64'(bus.grant_slot), 64'd5);
      bus.s_rdat_valid = 1'b1;
      #1 check("r_valid_issue", 64'(bus.m_rdat_valid), 64'd0);
      tick();
      bus.s_rdat_valid = 1'b0;
      bus.s_finish_wresp = 1'b1;
      tick();
      bus.s_finish_wresp = 1'b0;
      check("r_wrong_fin", 64'(bus.m_finish_wresp), 64'd0);
      check("r_wrong_busy", 64'(bus.busy), 64'd1);
      for (int b = 0; b < 4; b++) begin
         bus.s_rdat_valid = 1'b1;
         bus.s_rdat_data  = {4{32'h5000_0000 + 32'(b)}};
         #1;
         check("r_valid_beat", 64'(bus.m_rdat_valid), 64'b100);
         check("r_data_beat", bus.m_rdat_data[63:0], {2{32'h5000_0000 + 32'(b)}});
         tick();
      end
      bus.s_rdat_valid = 1'b0;
      #1 check("r_valid_gap", 64'(bus.m_rdat_valid), 64'd0);
      bus.s_finish_mrd = 1'b1;
      tick();
      bus.s_finish_mrd = 1'b0;
      check("r_fin", 64'(bus.m_finish_mrd), 64'b100);
      tick();
      check("r_fin_pulse", 64'(bus.m_finish_mrd), 64'd0);

      // Contention: all six slots at once after reset
      apply_reset();
      bus.m_wstart_rq = '1;
      bus.m_rstart_rq = '1;
      tick();
      bus.m_wstart_rq = '0;
      bus.m_rstart_rq = '0;
      for (int s = 0; s < 6; s++) serve("cont", s, 1'b0);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.s_wstart_rq || bus.s_rstart_rq || bus.busy) extra++;
      end
      check("cont_drained", 64'(extra), 64'd0);

      // Fairness: master 0 write re-requests while master 2 read waits
      bus.m_wstart_rq[0] = 1'b1;
      bus.m_rstart_rq[2] = 1'b1;
      tick();
      bus.m_wstart_rq = '0;
      bus.m_rstart_rq = '0;
      serve("fair_a", 0, 1'b1);
      serve("fair_b", 5, 1'b0);
      serve("fair_c", 0, 1'b0);

      // Overrun: master 0 write pulsed again before finishing
      bus.m_wstart_rq[0] = 1'b1;
      tick();
      bus.m_wstart_rq = '0;
      tick();
      check("ovr_start", 64'(bus.s_wstart_rq), 64'd1);
      bus.m_wstart_rq[0] = 1'b1;
      tick();
      bus.m_wstart_rq = '0;
      check("ovr_err", 64'(bus.err_ovr), 64'b001);
      bus.s_finish_wresp = 1'b1;
      tick();
      bus.s_finish_wresp = 1'b0;
      check("ovr_fin", 64'(bus.m_finish_wresp), 64'b001);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.s_wstart_rq || bus.s_rstart_rq) extra++;
      end
      check("ovr_single_issue", 64'(extra), 64'd0);
      check("ovr_sticky", 64'(bus.err_ovr), 64'b001);

      // Reset while in WAIT_R
      bus.m_rstart_rq[1] = 1'b1;
      tick();
      bus.m_rstart_rq = '0;
      wait_start(ok);
      check("rr_grant", 64'(bus.grant_slot), 64'd3);
      tick();
      bus.s_rdat_valid = 1'b1;
      #1 check("rr_valid", 64'(bus.m_rdat_valid), 64'b010);
      #2 rst_n = 1'b0;
      #1;
      check("rr_busy", 64'(bus.busy), 64'd0);
      check("rr_valid_rst", 64'(bus.m_rdat_valid), 64'd0);
      check("rr_grant_rst", 64'(bus.grant_slot), 64'd5);
      check("rr_err_rst", 64'(bus.err_ovr), 64'd0);
      check("rr_raddr_rst", 64'(bus.s_rin_addr), 64'd0);
      tick();
      bus.s_rdat_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus.s_finish_mrd = 1'b1;
      tick();
      bus.s_finish_mrd = 1'b0;
      check("rr_stray_fin", 64'(bus.m_finish_mrd), 64'd0);
      check("rr_stray_busy", 64'(bus.busy), 64'd0);
      tick();
      check("rr_stray_fin2", 64'(bus.m_finish_mrd), 64'd0);
      bus.m_wstart_rq = 3'b011;
      tick();
      bus.m_wstart_rq = '0;
      serve("rr_new0", 0, 1'b0);
      serve("rr_new1", 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
